xadc_monitor_ctrl: RTL
======================

Name: xadc_monitor_ctrl

Overview:
Parametrised ADC monitor controller that sits between the Xilinx XADC primitive and the MOPS-Hub status logic.
- On each end-of-conversion it issues a DRP read for the converted channel and accumulates 2^AVG_LOG2 samples per channel.
- It publishes a per-channel average, drives per-channel over-threshold alarms with hysteresis, and serves channel values to a register-readout port.
- It generalises the single-channel passthrough temperature wrapper to N_CH channels, with averaging, alarms, timeout and overrun detection.

Parameters:
N_CH, 4, number of monitored channels (1..16)
CH_W, 2, width of channel index, ceil(log2(N_CH)), minimum 1
CH_BASE, 0, XADC channel number mapped to index 0 (0x00 = on-chip temperature)
DATA_W, 12, ADC result bits, taken from drp_do[15:16-DATA_W]
AVG_LOG2, 2, log2 of samples per average (0..6)
TIMEOUT, 63, max cycles to wait for drp_drdy

Ports:
clk  in  1  DRP/system clock
reset  in  1  synchronous, active-high
eoc_in  in  1  end-of-conversion pulse from XADC
channel_in  in  5  XADC channel of the finished conversion
drp_den  out  1  DRP enable, one-cycle pulse
drp_daddr  out  7  DRP address, {2'b00, latched channel}
drp_do  in  16  DRP read data
drp_drdy  in  1  DRP data ready
thr_hi  in  DATA_W  alarm set threshold, global to all channels
thr_lo  in  DATA_W  alarm clear threshold, global to all channels
rd_req  in  1  readout request
rd_ch  in  CH_W  readout channel index
rd_data  out  16  {alarm, avg_valid, 2'b0, avg[DATA_W-1:0] zero-extended to 12 bits}
rd_valid  out  1  one-cycle strobe qualifying rd_data
alarm_out  out  N_CH  per-channel alarm level
avg_strobe  out  1  one-cycle pulse when any average updates
err_timeout  out  1  one-cycle pulse on DRP timeout
err_overrun  out  1  one-cycle pulse when eoc_in is dropped

Behaviour:
- Reset:
  - All outputs 0.
  - Accumulators, sample counters, averages, avg_valid flags, alarms and the FSM (IDLE) are cleared.
  - A reset in any state aborts the pending DRP read; a late drp_drdy is ignored in IDLE.
- Channel mapping: idx = channel_in - CH_BASE. If channel_in < CH_BASE or idx >= N_CH, the eoc is ignored, with no DRP access and no error.
- FSM:
  - IDLE: on eoc_in with a mapped channel, latch channel and idx -> REQ.
  - REQ: drp_den=1 for exactly one cycle, drp_daddr={2'b00,chan}, clear timer -> WAIT.
  - WAIT:
    - drp_drdy=1: capture sample = drp_do[15:16-DATA_W] -> ACC.
    - Otherwise the timer increments; when it reaches TIMEOUT, pulse err_timeout -> IDLE, and no accumulator change.
  - ACC:
    - acc[idx] += sample; cnt[idx]++.
    - If cnt wraps to 0 (2^AVG_LOG2 samples): avg[idx] = acc >> AVG_LOG2 (truncate), acc cleared, avg_valid[idx]=1, avg_strobe=1 -> CMP.
    - Otherwise -> IDLE.
  - CMP:
    - If avg[idx] > thr_hi, alarm[idx]=1.
    - Else if avg[idx] < thr_lo, alarm[idx]=0.
    - Else alarm[idx] holds.
    - -> IDLE.
- Accumulator width: DATA_W+AVG_LOG2, which cannot overflow. Comparisons are unsigned.
- Overrun: eoc_in for a mapped channel arriving in REQ, WAIT, ACC or CMP is dropped, and err_overrun pulses in that cycle. An eoc_in in the same cycle the FSM returns to IDLE is also dropped; IDLE samples eoc_in only while in IDLE.
- Latency: eoc_in to drp_den is 1 cycle. drp_drdy to avg_strobe is 1 cycle (ACC cycle). Alarms update the cycle after avg_strobe.
- Readout:
  - rd_req registers rd_data and rd_valid one cycle later, independent of the FSM.
  - rd_ch >= N_CH returns 0 with rd_valid=1.
  - A read coinciding with an average update returns the old value.
- thr_lo > thr_hi is a misconfiguration: set takes priority, and there is no special handling.

Decomposition:
- Package xadc_mon_pkg: FSM state enum (IDLE, REQ, WAIT, ACC, CMP), DRP address pad width constant (2), rd_data field offsets.
- One sub-module: xadc_mon_chan_avg (per-channel accumulator/counter/average/alarm), instantiated N_CH times via generate.
- The FSM and readout mux stay in the top.

Test Plan:
- Default params, 4 eoc_in on channel 0 with drp_do=0x9770 (code 0x977, 25 C) -> avg_strobe on the 4th; rd_ch=0 gives rd_data=0x4977 (valid=1, alarm=0).
- Samples 0x100, 0x200, 0x300, 0x400 on channel 2 -> avg 0x280. Channel 1 untouched reads 0x0000. rd_ch=3 before any sample reads 0.
- thr_hi=0xA00, thr_lo=0x900: avg 0xA10 -> alarm_out[0]=1; then avg 0x950 -> stays 1; then avg 0x8F0 -> 0.
- eoc_in and no drp_drdy -> err_timeout pulses exactly TIMEOUT+1 cycles after drp_den. Accumulator unchanged; the next eoc is serviced normally.
- Second eoc_in during WAIT -> err_overrun=1 for one cycle, no second drp_den. channel_in=5 with N_CH=4 -> ignored, no den.
- Assert reset for 1 cycle during WAIT with 2 samples accumulated -> all outputs 0. Late drp_drdy is ignored; 4 fresh samples are needed for the next avg_strobe.

Source files
------------

// File: rtl/xadc_mon_pkg.sv
// Shared types and constants for the XADC monitor controller.
package xadc_mon_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ACC,
        CMP
    } state_t;

    localparam int unsigned XADC_CH_W    = 5;
    localparam int unsigned DRP_PAD_W    = 2;
    localparam int unsigned DRP_ADDR_W   = DRP_PAD_W + XADC_CH_W;
    localparam int unsigned DRP_DATA_W   = 16;

    // Readout word layout.
    localparam int unsigned RD_W         = 16;
    localparam int unsigned RD_ALARM_BIT = 15;
    localparam int unsigned RD_VALID_BIT = 14;
    localparam int unsigned RD_AVG_W     = 12;

    typedef struct packed {
        logic                alarm;
        logic                avg_valid;
        logic [1:0]          rsvd;
        logic [RD_AVG_W-1:0] avg;
    } rd_word_t;

endpackage

// File: rtl/xadc_monitor_ctrl_if.sv
// DRP access and register-readout signals between the monitor and its neighbours.
interface xadc_monitor_ctrl_if
    import xadc_mon_pkg::*;
#(
    parameter int unsigned CH_W = 2
);
    logic                  drp_den;
    logic [DRP_ADDR_W-1:0] drp_daddr;
    logic [DRP_DATA_W-1:0] drp_do;
    logic                  drp_drdy;
    logic                  rd_req;
    logic [CH_W-1:0]       rd_ch;
    logic [RD_W-1:0]       rd_data;
    logic                  rd_valid;

    modport master (
        output drp_den, drp_daddr, rd_data, rd_valid,
        input  drp_do, drp_drdy, rd_req, rd_ch
    );

    modport slave (
        input  drp_den, drp_daddr, rd_data, rd_valid,
        output drp_do, drp_drdy, rd_req, rd_ch
    );

endinterface

// File: rtl/xadc_mon_chan_avg.sv
// One channel: sample accumulator, block average and hysteresis alarm.
module xadc_mon_chan_avg #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_en,
    input  logic              cmp_en,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic [DATA_W-1:0] avg,
    output logic              avg_valid,
    output logic              alarm,
    output logic              full_c
);

    localparam int unsigned ACC_W   = DATA_W + AVG_LOG2;
    localparam int unsigned CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned CNT_MAX = (1 << AVG_LOG2) - 1;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum_c;
    logic [CNT_W-1:0] cnt_q;

    // Sum is sized so a full block of max-code samples cannot overflow.
    assign sum_c  = acc_q + ACC_W'(sample);
    assign full_c = (cnt_q == CNT_W'(CNT_MAX));

    // Accumulate; on the last sample of a block publish the truncated mean.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else if (acc_en) begin
            if (full_c) begin
                avg       <= DATA_W'(sum_c >> AVG_LOG2);
                acc_q     <= '0;
                cnt_q     <= '0;
                avg_valid <= 1'b1;
            end else begin
                acc_q <= sum_c;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Set above thr_hi, clear below thr_lo, hold in between (set wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm <= 1'b0;
        end else if (cmp_en) begin
            if (avg > thr_hi) begin
                alarm <= 1'b1;
            end else if (avg < thr_lo) begin
                alarm <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/xadc_monitor_ctrl.sv
// Multi-channel XADC monitor: DRP fetch on EOC, per-channel averaging, alarms, readout.
module xadc_monitor_ctrl
    import xadc_mon_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned CH_BASE  = 0,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 63
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 eoc_in,
    input  logic [XADC_CH_W-1:0] channel_in,
    input  logic [DATA_W-1:0]    thr_hi,
    input  logic [DATA_W-1:0]    thr_lo,
    output logic [N_CH-1:0]      alarm_out,
    output logic                 avg_strobe,
    output logic                 err_timeout,
    output logic                 err_overrun,
    xadc_monitor_ctrl_if.master  bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   idx_q;
    logic [TMR_W-1:0]  timer_q;
    logic [DATA_W-1:0] sample_q;
    logic              timeout_c;

    logic [XADC_CH_W:0] ch_diff_c;
    logic               mapped_c;
    logic               start_c;
    logic               full_sel_c;

    logic [DATA_W-1:0] avg_a [N_CH];
    logic [N_CH-1:0]   valid_v;
    logic [N_CH-1:0]   alarm_v;
    logic [N_CH-1:0]   full_v;
    logic [N_CH-1:0]   acc_en_v;
    logic [N_CH-1:0]   cmp_en_v;
    rd_word_t          rd_word_c;

    // Borrow bit of the subtraction flags channels below CH_BASE.
    assign ch_diff_c = {1'b0, channel_in} - (XADC_CH_W + 1)'(CH_BASE);
    assign mapped_c  = !ch_diff_c[XADC_CH_W] && (32'(ch_diff_c[XADC_CH_W-1:0]) < N_CH);
    assign start_c   = (state == IDLE) && eoc_in && mapped_c;

    // A mapped EOC while busy is lost; flagged in the same cycle.
    assign err_overrun = !reset && eoc_in && mapped_c && (state != IDLE);

    // Per-channel strobes and selection of the active channel's block-full flag.
    always_comb begin
        acc_en_v   = '0;
        cmp_en_v   = '0;
        full_sel_c = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (idx_q == CH_W'(i)) begin
                acc_en_v[i] = (state == ACC);
                cmp_en_v[i] = (state == CMP);
                full_sel_c  = full_v[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (start_c) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.drp_drdy) begin
                    state_nxt = ACC;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ACC: begin
                state_nxt = full_sel_c ? CMP : IDLE;
            end
            CMP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Channel latch, DRP request, wait timer, sample capture and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q         <= '0;
            timer_q       <= '0;
            sample_q      <= '0;
            bus.drp_den   <= 1'b0;
            bus.drp_daddr <= '0;
            avg_strobe    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            bus.drp_den <= start_c;
            avg_strobe  <= (state == WAIT) && bus.drp_drdy && full_sel_c;
            err_timeout <= timeout_c;
            if (start_c) begin
                idx_q         <= CH_W'(ch_diff_c[XADC_CH_W-1:0]);
                bus.drp_daddr <= {DRP_PAD_W'(0), channel_in};
            end
            if (state == REQ) begin
                timer_q <= '0;
            end else if (state == WAIT) begin
                timer_q <= timer_q + TMR_W'(1);
            end
            if ((state == WAIT) && bus.drp_drdy) begin
                sample_q <= bus.drp_do[DRP_DATA_W-1 -: DATA_W];
            end
        end
    end

    generate
        if (DATA_W < DRP_DATA_W) begin : g_drp_low
            logic unused_drp_low;
            assign unused_drp_low = ^bus.drp_do[DRP_DATA_W-1-DATA_W:0];
        end
    endgenerate

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        xadc_mon_chan_avg #(
            .DATA_W   (DATA_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .acc_en    (acc_en_v[g]),
            .cmp_en    (cmp_en_v[g]),
            .sample    (sample_q),
            .thr_hi    (thr_hi),
            .thr_lo    (thr_lo),
            .avg       (avg_a[g]),
            .avg_valid (valid_v[g]),
            .alarm     (alarm_v[g]),
            .full_c    (full_v[g])
        );
    end

    assign alarm_out = alarm_v;

    // Readout word mux; out-of-range indices read as zero.
    always_comb begin
        rd_word_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(bus.rd_ch) == i) begin
                rd_word_c.alarm     = alarm_v[i];
                rd_word_c.avg_valid = valid_v[i];
                rd_word_c.avg       = RD_AVG_W'(avg_a[i]);
            end
        end
    end

    // Registered readout, one cycle after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                bus.rd_data <= rd_word_c;
            end
        end
    end

endmodule
